t09_lcd_bus_receiver: RTL and testbench



---
 rtl/t09_lcd_bus_receiver.sv | 160 ++++++++++++++++
 tb/tb_t09_lcd_bus_receiver.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/t09_lcd_bus_receiver.sv
// Display-side responder for an 8-bit 8080-style write bus: decodes commands,
// tracks the CASET/PASET window and turns RAMWR data into addressed RGB565 pixel writes.
module t09_lcd_bus_receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       dcx,
  input  logic [7:0] D,
  output logic       pix_valid,
  output logic [8:0] pix_x,
  output logic [8:0] pix_y,
  output logic [15:0] pix_rgb,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       disp_on,
  output logic       sleeping,
  output logic       stray_data
);

  typedef enum logic [2:0] {S_IDLE, S_CA, S_PA, S_RAM, S_SKIP} state_t;

  localparam logic [8:0] EC_RST = 9'd239;
  localparam logic [8:0] EP_RST = 9'd319;

  state_t     state, state_nx;
  logic       wr_q;
  logic       strobe;
  logic [1:0] cnt;
  logic [8:0] sh_start;
  logic       sh_end_hi;
  logic [8:0] sc, ec, sp, ep;
  logic [8:0] col, row;
  logic       phase;
  logic [7:0] hi_byte;

  assign strobe = wr & ~wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (strobe) begin
      if (!dcx) begin
        unique case (D)
          8'h2A:                             state_nx = S_CA;
          8'h2B:                             state_nx = S_PA;
          8'h2C:                             state_nx = S_RAM;
          8'h01, 8'h10, 8'h11, 8'h28, 8'h29: state_nx = S_IDLE;
          default:                           state_nx = S_SKIP;
        endcase
      end else if ((state == S_CA || state == S_PA) && cnt == 2'd3) begin
        state_nx = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= 1'b1;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      disp_on    <= 1'b0;
      sleeping   <= 1'b1;
      stray_data <= 1'b0;
      cnt        <= '0;
      sh_start   <= '0;
      sh_end_hi  <= 1'b0;
      sc         <= '0;
      ec         <= EC_RST;
      sp         <= '0;
      ep         <= EP_RST;
      col        <= '0;
      row        <= '0;
      phase      <= 1'b0;
      hi_byte    <= '0;
    end else begin
      wr_q       <= wr;
      pix_valid  <= 1'b0;
      cmd_valid  <= 1'b0;
      stray_data <= 1'b0;
      if (strobe && !dcx) begin
        // Any command abandons partial window bytes and a pending odd pixel byte.
        cmd_valid <= 1'b1;
        cmd_code  <= D;
        cnt       <= '0;
        phase     <= 1'b0;
        unique case (D)
          8'h2C: begin
            col <= sc;
            row <= sp;
          end
          8'h01: begin
            sc       <= '0;
            ec       <= EC_RST;
            sp       <= '0;
            ep       <= EP_RST;
            col      <= '0;
            row      <= '0;
            disp_on  <= 1'b0;
            sleeping <= 1'b1;
          end
          8'h11:   sleeping <= 1'b0;
          8'h10:   sleeping <= 1'b1;
          8'h29:   disp_on  <= 1'b1;
          8'h28:   disp_on  <= 1'b0;
          default: ;
        endcase
      end else if (strobe && dcx) begin
        unique case (state)
          S_IDLE: stray_data <= 1'b1;
          S_CA, S_PA: begin
            cnt <= cnt + 2'd1;
            unique case (cnt)
              2'd0: sh_start[8]   <= D[0];
              2'd1: sh_start[7:0] <= D;
              2'd2: sh_end_hi     <= D[0];
              2'd3: begin
                if (state == S_CA) begin
                  sc <= sh_start;
                  ec <= {sh_end_hi, D};
                end else begin
                  sp <= sh_start;
                  ep <= {sh_end_hi, D};
                end
              end
              default: ;
            endcase
          end
          S_RAM: begin
            phase <= ~phase;
            if (!phase) begin
              hi_byte <= D;
            end else begin
              pix_valid <= 1'b1;
              pix_x     <= col;
              pix_y     <= row;
              pix_rgb   <= {hi_byte, D};
              // >= comparisons make an inverted window (start > end) wrap on every pixel.
              if (col >= ec) begin
                col <= sc;
                row <= (row >= ep) ? sp : row + 9'd1;
              end else begin
                col <= col + 9'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t09_lcd_bus_receiver.sv
// Directed bench for t09_lcd_bus_receiver: bytes are strobed at full rate and
// outputs are sampled 1 time unit after the edge that registers them.
module tb_t09_lcd_bus_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr  = 1'b1;
  logic        dcx = 1'b0;
  logic [7:0]  D   = '0;
  logic        pix_valid;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_rgb;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        disp_on, sleeping, stray_data;

  int total = 0;
  int bad   = 0;
  int npix  = 0;

  t09_lcd_bus_receiver dut (
    .clk(clk), .rst(rst), .wr(wr), .dcx(dcx), .D(D),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .disp_on(disp_on),
    .sleeping(sleeping), .stray_data(stray_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pix_valid) npix <= npix + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // wr low for one cycle, then high for one; returns 1 unit after the edge's posedge.
  task automatic send(input logic c, input logic [7:0] b);
    wr = 1'b0;
    @(posedge clk); #1;
    wr = 1'b1; dcx = c; D = b;
    @(posedge clk); #1;
  endtask

  task automatic pixel(input string tag, input logic [15:0] v, input int ex, input int ey);
    send(1'b1, v[15:8]);
    check({tag, "_hi_nopix"}, pix_valid, 1'b0);
    send(1'b1, v[7:0]);
    check({tag, "_valid"}, pix_valid, 1'b1);
    check({tag, "_x"}, pix_x, ex);
    check({tag, "_y"}, pix_y, ey);
    check({tag, "_rgb"}, pix_rgb, v);
  endtask

  int n0;

  initial begin
    // Reset defaults with wr held high across release.
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_no_pulse", {pix_valid, cmd_valid, stray_data}, 3'b000);
    end
    check("rst_sleeping", sleeping, 1'b1);
    check("rst_disp_on", disp_on, 1'b0);
    check("rst_cmd_code", cmd_code, 8'h00);
    check("rst_pix", {pix_x, pix_y, pix_rgb}, 34'h0);
    send(1'b0, 8'h2C);
    check("ramwr_cmd_valid", cmd_valid, 1'b1);
    check("ramwr_cmd_code", cmd_code, 8'h2C);
    pixel("first", 16'h1234, 0, 0);

    // Abort partial CASET with RAMWR.
    send(1'b0, 8'h2A);
    send(1'b1, 8'h00);
    send(1'b1, 8'h05);
    send(1'b1, 8'h00);
    send(1'b0, 8'h2C);
    check("abort_cmd_valid", cmd_valid, 1'b1);
    pixel("abort", 16'hBEEF, 0, 0);

    // Odd RAMWR byte dropped by a command; then stray data.
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAA);
    send(1'b0, 8'h29);
    check("odd_nopix", pix_valid, 1'b0);
    check("odd_disp_on", disp_on, 1'b1);
    send(1'b1, 8'h55);
    check("stray", stray_data, 1'b1);
    send(1'b0, 8'h11);
    check("wake", sleeping, 1'b0);
    send(1'b0, 8'hB0);
    check("skip_cmd_code", cmd_code, 8'hB0);
    send(1'b1, 8'h77);
    check("skip_no_stray", {stray_data, pix_valid}, 2'b00);

    // Small window wrap.
    send(1'b0, 8'h2A);
    send(1'b1, 8'h00); send(1'b1, 8'h0A); send(1'b1, 8'h00); send(1'b1, 8'h0B);
    send(1'b1, 8'h99);
    check("caset_then_stray", stray_data, 1'b1);
    send(1'b0, 8'h2B);
    send(1'b1, 8'h00); send(1'b1, 8'h14); send(1'b1, 8'h00); send(1'b1, 8'h15);
    send(1'b0, 8'h2C);
    pixel("wrap0", 16'h0101, 10, 20);
    pixel("wrap1", 16'h0202, 11, 20);
    pixel("wrap2", 16'h0303, 10, 21);
    pixel("wrap3", 16'h0404, 11, 21);
    pixel("wrap4", 16'h0505, 10, 20);

    // SWRESET, then full-rate stream in the default window.
    send(1'b0, 8'h01);
    check("swrst_code", cmd_code, 8'h01);
    check("swrst_disp", disp_on, 1'b0);
    check("swrst_sleep", sleeping, 1'b1);
    send(1'b0, 8'h2C);
    n0 = npix;
    for (int i = 0; i < 100; i++) pixel("full", 16'(i * 3 + 1), i, 0);
    @(posedge clk); #1;
    check("full_count", npix - n0, 100);

    // 9-bit column.
    send(1'b0, 8'h2A);
    send(1'b1, 8'h01); send(1'b1, 8'h3F); send(1'b1, 8'h01); send(1'b1, 8'h3F);
    send(1'b0, 8'h2C);
    pixel("col319a", 16'hC0DE, 319, 0);
    pixel("col319b", 16'hF00D, 319, 1);

    // Async reset between hi and lo bytes.
    send(1'b0, 8'h2C);
    send(1'b1, 8'h9A);
    #2 rst = 1'b1;
    #1;
    check("arst_nopix", pix_valid, 1'b0);
    check("arst_code", cmd_code, 8'h00);
    check("arst_sleep", sleeping, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    send(1'b1, 8'hBC);
    check("arst_idle_stray", stray_data, 1'b1);
    check("arst_lo_nopix", pix_valid, 1'b0);
    send(1'b0, 8'h2C);
    pixel("arst_p0", 16'h1111, 0, 0);
    pixel("arst_p1", 16'h2222, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
